// File: rtl/gelato_decode_pkg.sv
// Shared types for the gelato decode stage: opcode constants, immediate
// format classification and the decoded-instruction record handed to issue.
package gelato_decode_pkg;

    localparam int XLEN  = 32;
    localparam int OPC_W = 7;
    localparam int REG_W = 5;
    localparam int F3_W  = 3;
    localparam int F7_W  = 7;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_MADD   = 7'b1000011;
    localparam logic [OPC_W-1:0] OPC_MSUB   = 7'b1000111;
    localparam logic [OPC_W-1:0] OPC_NMSUB  = 7'b1001011;
    localparam logic [OPC_W-1:0] OPC_NMADD  = 7'b1001111;

    // FMT_NONE marks an opcode outside the supported set
    typedef enum logic [2:0] {
        FMT_R,
        FMT_R4,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_NONE
    } imm_fmt_e;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rs3;
        logic [XLEN-1:0]  imm;
        logic [F3_W-1:0]  funct3;
        logic [F7_W-1:0]  funct7;
    } gelato_inst_t;

    function automatic imm_fmt_e imm_fmt(input logic [OPC_W-1:0] opc);
        imm_fmt_e f;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR:            f = FMT_I;
            OPC_STORE:                                 f = FMT_S;
            OPC_BRANCH:                                f = FMT_B;
            OPC_LUI, OPC_AUIPC:                        f = FMT_U;
            OPC_JAL:                                   f = FMT_J;
            OPC_OP:                                    f = FMT_R;
            OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD:  f = FMT_R4;
            default:                                   f = FMT_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/gelato_inst_decoder.sv
// Combinational instruction cracker: raw 32-bit word -> decoded fields plus
// an illegal flag. Unsupported opcodes still get their raw register/funct
// fields so issue can report the trap with context.
module gelato_inst_decoder
    import gelato_decode_pkg::*;
(
    input  logic [XLEN-1:0] inst_i,
    output gelato_inst_t    dec_o,
    output logic            illegal_o
);

    imm_fmt_e fmt;
    logic     sgn;

    // Field extraction and immediate assembly by format
    always_comb begin
        fmt        = imm_fmt(inst_i[6:0]);
        sgn        = inst_i[31];
        dec_o      = '0;
        dec_o.opcode = inst_i[6:0];
        dec_o.rd     = inst_i[11:7];
        dec_o.rs1    = inst_i[19:15];
        dec_o.rs2    = inst_i[24:20];
        dec_o.funct3 = inst_i[14:12];
        dec_o.funct7 = inst_i[31:25];
        illegal_o    = (fmt == FMT_NONE);
        case (fmt)
            FMT_I: dec_o.imm = {{20{sgn}}, inst_i[31:20]};
            FMT_S: begin
                dec_o.imm = {{20{sgn}}, inst_i[31:25], inst_i[11:7]};
                dec_o.rd  = '0;
            end
            FMT_B: begin
                dec_o.imm = {{19{sgn}}, sgn, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
                dec_o.rd  = '0;
            end
            FMT_U:  dec_o.imm = {inst_i[31:12], 12'b0};
            FMT_J:  dec_o.imm = {{11{sgn}}, sgn, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            FMT_R4: dec_o.rs3 = inst_i[31:27];
            default: ;
        endcase
    end

endmodule

// File: rtl/gelato_decode.sv
// Decode stage between fetch and issue. One output register plus one skid
// entry, so fetch_ready can be a plain flop with no path from dec_ready.
//
//  state    | meaning
//  ---------+-----------------------------------------------
//  ST_EMPTY | output register invalid, skid invalid
//  ST_BUSY  | output register valid, skid invalid
//  ST_FULL  | output and skid valid, fetch_ready held low
module gelato_decode
    import gelato_decode_pkg::*;
#(
    parameter int WARP_ID_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 fetch_valid,
    output logic                 fetch_ready,
    input  logic [XLEN-1:0]      fetch_inst,
    input  logic [XLEN-1:0]      fetch_pc,
    input  logic [WARP_ID_W-1:0] fetch_warp,
    output logic                 dec_valid,
    input  logic                 dec_ready,
    output gelato_inst_t         dec_inst,
    output logic [XLEN-1:0]      dec_pc,
    output logic [WARP_ID_W-1:0] dec_warp,
    output logic                 dec_illegal
);

    typedef struct packed {
        gelato_inst_t          inst;
        logic [XLEN-1:0]       pc;
        logic [WARP_ID_W-1:0]  warp;
        logic                  illegal;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_BUSY,
        ST_FULL
    } occ_e;

    occ_e         state_q;
    entry_t       out_q;
    entry_t       skid_q;
    logic         fetch_ready_q;
    logic         dec_valid_q;
    entry_t       new_entry;
    gelato_inst_t new_inst;
    logic         new_illegal;
    logic         fetch_xfer;
    logic         dec_xfer;

    gelato_inst_decoder u_dec (
        .inst_i    (fetch_inst),
        .dec_o     (new_inst),
        .illegal_o (new_illegal)
    );

    assign new_entry  = '{inst: new_inst, pc: fetch_pc, warp: fetch_warp, illegal: new_illegal};
    assign fetch_xfer = fetch_valid && fetch_ready_q;
    assign dec_xfer   = dec_valid_q && dec_ready;

    // Occupancy FSM; a dec transfer in a flush cycle needs no special handling
    // because flush empties everything anyway.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_EMPTY;
            fetch_ready_q <= 1'b1;
            dec_valid_q   <= 1'b0;
            out_q         <= '0;
            skid_q        <= '0;
        end else if (flush) begin
            state_q       <= ST_EMPTY;
            fetch_ready_q <= 1'b1;
            dec_valid_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (fetch_xfer) begin
                        out_q       <= new_entry;
                        dec_valid_q <= 1'b1;
                        state_q     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (fetch_xfer && dec_xfer) begin
                        out_q <= new_entry;
                    end else if (fetch_xfer) begin
                        skid_q        <= new_entry;
                        fetch_ready_q <= 1'b0;
                        state_q       <= ST_FULL;
                    end else if (dec_xfer) begin
                        dec_valid_q <= 1'b0;
                        state_q     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (dec_xfer) begin
                        out_q         <= skid_q;
                        fetch_ready_q <= 1'b1;
                        state_q       <= ST_BUSY;
                    end
                end
                default: begin
                    state_q       <= ST_EMPTY;
                    fetch_ready_q <= 1'b1;
                    dec_valid_q   <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_ready = fetch_ready_q;
    assign dec_valid   = dec_valid_q;
    assign dec_inst    = out_q.inst;
    assign dec_pc      = out_q.pc;
    assign dec_warp    = out_q.warp;
    assign dec_illegal = out_q.illegal;

endmodule
